// File: rtl/vga_pkg.sv
// Shared 640x480@60 VGA timing constants and a small window-decode helper.
// Imported by the timing generator, the colour stage and benches.
package vga_pkg;

    localparam int unsigned HVisible = 640;
    localparam int unsigned HFp      = 16;
    localparam int unsigned HSync    = 96;
    localparam int unsigned HBp      = 48;
    localparam int unsigned VVisible = 480;
    localparam int unsigned VFp      = 10;
    localparam int unsigned VSync    = 2;
    localparam int unsigned VBp      = 33;

    localparam int unsigned HTotal     = HVisible + HFp + HSync + HBp;
    localparam int unsigned VTotal     = VVisible + VFp + VSync + VBp;
    localparam int unsigned HSyncStart = HVisible + HFp;
    localparam int unsigned HSyncEnd   = HSyncStart + HSync;
    localparam int unsigned VSyncStart = VVisible + VFp;
    localparam int unsigned VSyncEnd   = VSyncStart + VSync;

    localparam int unsigned CoordW = 10;
    localparam int unsigned YOutW  = 9;
    localparam int unsigned FrameW = 32;

    // Half-open window test: lo <= v < hi.
    function automatic logic in_window(input logic [CoordW-1:0] v,
                                       input logic [CoordW-1:0] lo,
                                       input logic [CoordW-1:0] hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Pixel-rate enable: one-clk pulse every CLK_DIV clocks (CLK_DIV in {1, 2, 4}).
// The pulse is registered so it reads low while reset is held.
module pixel_tick_gen #(
    parameter int unsigned CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    output logic pixel_tick
);

    localparam logic [1:0] CntLast = 2'(CLK_DIV - 1);

    logic [1:0] cnt_q, cnt_d;
    logic       tick_q, tick_d;

    always_comb begin
        cnt_d  = (cnt_q == CntLast) ? 2'd0 : cnt_q + 2'd1;
        tick_d = (cnt_d == CntLast);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= 2'd0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign pixel_tick = tick_q;

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing generator: next/current coordinates, frame count, registered syncs.
// Optional VGA_TIMING_PAUSE_EN adds a pause input that suppresses the frame increment.
module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned H_VISIBLE = HVisible,
    parameter int unsigned H_FP      = HFp,
    parameter int unsigned H_SYNC    = HSync,
    parameter int unsigned H_BP      = HBp,
    parameter int unsigned V_VISIBLE = VVisible,
    parameter int unsigned V_FP      = VFp,
    parameter int unsigned V_SYNC    = VSync,
    parameter int unsigned V_BP      = VBp,
    parameter int unsigned CLK_DIV   = 1,
    parameter bit          SYNC_POL  = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
`ifdef VGA_TIMING_PAUSE_EN
    input  logic              pause,
`endif
    output logic              pixel_tick,
    output logic [CoordW-1:0] position_x_NEXT,
    output logic [YOutW-1:0]  position_y_NEXT,
    output logic [CoordW-1:0] position_x,
    output logic [YOutW-1:0]  position_y,
    output logic [FrameW-1:0] frame,
    output logic              hsync,
    output logic              vsync,
    output logic              visible
);

    localparam int unsigned HTot = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned VTot = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [CoordW-1:0] XLast   = CoordW'(HTot - 1);
    localparam logic [CoordW-1:0] YLast   = CoordW'(VTot - 1);
    localparam logic [CoordW-1:0] XVis    = CoordW'(H_VISIBLE);
    localparam logic [CoordW-1:0] YVis    = CoordW'(V_VISIBLE);
    localparam logic [CoordW-1:0] HsStart = CoordW'(H_VISIBLE + H_FP);
    localparam logic [CoordW-1:0] HsEnd   = CoordW'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [CoordW-1:0] VsStart = CoordW'(V_VISIBLE + V_FP);
    localparam logic [CoordW-1:0] VsEnd   = CoordW'(V_VISIBLE + V_FP + V_SYNC);

    logic [CoordW-1:0] x_next_q, x_next_d, y_next_q, y_next_d, x_q, x_d;
    logic [YOutW-1:0]  y_q, y_d;
    logic [FrameW-1:0] frame_q, frame_d;
    logic              hsync_q, hsync_d, vsync_q, vsync_d, visible_q, visible_d;
    logic              frame_wrap, frame_hold;

    pixel_tick_gen #(
        .CLK_DIV    (CLK_DIV)
    ) u_pixel_tick_gen (
        .clk        (clk),
        .rst        (rst),
        .pixel_tick (pixel_tick)
    );

`ifdef VGA_TIMING_PAUSE_EN
    assign frame_hold = pause;
`else
    assign frame_hold = 1'b0;
`endif

    assign frame_wrap = (x_next_q == XLast) && (y_next_q == YLast);

    always_comb begin
        x_next_d  = x_next_q;
        y_next_d  = y_next_q;
        x_d       = x_q;
        y_d       = y_q;
        frame_d   = frame_q;
        hsync_d   = hsync_q;
        vsync_d   = vsync_q;
        visible_d = visible_q;
        if (pixel_tick) begin
            x_d       = x_next_q;
            y_d       = y_next_q[YOutW-1:0];
            // Decode from NEXT so the registered flags line up with the current position.
            hsync_d   = in_window(x_next_q, HsStart, HsEnd) ? SYNC_POL : ~SYNC_POL;
            vsync_d   = in_window(y_next_q, VsStart, VsEnd) ? SYNC_POL : ~SYNC_POL;
            visible_d = (x_next_q < XVis) && (y_next_q < YVis);
            if (x_next_q == XLast) begin
                x_next_d = '0;
                y_next_d = (y_next_q == YLast) ? '0 : y_next_q + 1'b1;
            end else begin
                x_next_d = x_next_q + 1'b1;
            end
            if (frame_wrap && !frame_hold) begin
                frame_d = frame_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_next_q  <= '0;
            y_next_q  <= '0;
            x_q       <= '0;
            y_q       <= '0;
            frame_q   <= '0;
            hsync_q   <= ~SYNC_POL;
            vsync_q   <= ~SYNC_POL;
            visible_q <= 1'b0;
        end else begin
            x_next_q  <= x_next_d;
            y_next_q  <= y_next_d;
            x_q       <= x_d;
            y_q       <= y_d;
            frame_q   <= frame_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            visible_q <= visible_d;
        end
    end

    assign position_x_NEXT = x_next_q;
    assign position_y_NEXT = y_next_q[YOutW-1:0];
    assign position_x      = x_q;
    assign position_y      = y_q;
    assign frame           = frame_q;
    assign hsync           = hsync_q;
    assign vsync           = vsync_q;
    assign visible         = visible_q;

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing: default 640x480 timing plus two shrunk rasters
// (CLK_DIV=1 with full 525 lines, CLK_DIV=4 active-high syncs) and a mid-frame reset.
module tb_vga_timing;

    logic clk = 1'b0;
    logic rst;
    logic pause_a, pause_b, pause_c;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    logic       a_tick, b_tick, c_tick;
    logic [9:0] a_px, a_pxn, b_px, b_pxn, c_px, c_pxn;
    logic [8:0] a_py, a_pyn, b_py, b_pyn, c_py, c_pyn;
    logic [31:0] a_fr, b_fr, c_fr;
    logic       a_hs, a_vs, a_vis, b_hs, b_vs, b_vis, c_hs, c_vs, c_vis;

    vga_timing u_dut_a (
        .clk             (clk),
        .rst             (rst),
`ifdef VGA_TIMING_PAUSE_EN
        .pause           (pause_a),
`endif
        .pixel_tick      (a_tick),
        .position_x_NEXT (a_pxn),
        .position_y_NEXT (a_pyn),
        .position_x      (a_px),
        .position_y      (a_py),
        .frame           (a_fr),
        .hsync           (a_hs),
        .vsync           (a_vs),
        .visible         (a_vis)
    );

    vga_timing #(
        .H_VISIBLE (8),
        .H_FP      (2),
        .H_SYNC    (3),
        .H_BP      (3)
    ) u_dut_b (
        .clk             (clk),
        .rst             (rst),
`ifdef VGA_TIMING_PAUSE_EN
        .pause           (pause_b),
`endif
        .pixel_tick      (b_tick),
        .position_x_NEXT (b_pxn),
        .position_y_NEXT (b_pyn),
        .position_x      (b_px),
        .position_y      (b_py),
        .frame           (b_fr),
        .hsync           (b_hs),
        .vsync           (b_vs),
        .visible         (b_vis)
    );

    vga_timing #(
        .H_VISIBLE (8),
        .H_FP      (2),
        .H_SYNC    (3),
        .H_BP      (3),
        .V_VISIBLE (6),
        .V_FP      (1),
        .V_SYNC    (2),
        .V_BP      (1),
        .CLK_DIV   (4),
        .SYNC_POL  (1'b1)
    ) u_dut_c (
        .clk             (clk),
        .rst             (rst),
`ifdef VGA_TIMING_PAUSE_EN
        .pause           (pause_c),
`endif
        .pixel_tick      (c_tick),
        .position_x_NEXT (c_pxn),
        .position_y_NEXT (c_pyn),
        .position_x      (c_px),
        .position_y      (c_py),
        .frame           (c_fr),
        .hsync           (c_hs),
        .vsync           (c_vs),
        .visible         (c_vis)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected raster state after t pixel ticks (t=0: nothing has advanced yet).
    task automatic check_pixel(input string inst, input int t, input int ht, input int vt,
                               input int hvis, input int vvis, input int hs0, input int hs1,
                               input int vs0, input int vs1, input bit pol,
                               input int unsigned exp_fr,
                               input logic [9:0] px, input logic [9:0] pxn,
                               input logic [8:0] py, input logic [8:0] pyn,
                               input logic [31:0] fr, input logic hs, input logic vs,
                               input logic vis);
        int    total, n, c, cx, cy, nx, ny;
        bit    e_hs, e_vs, e_vis;
        string tag;
        total = ht * vt;
        tag   = $sformatf("%s t=%0d", inst, t);
        if (t == 0) begin
            cx = 0; cy = 0; nx = 0; ny = 0;
            e_hs = ~pol; e_vs = ~pol; e_vis = 1'b0;
        end else begin
            n  = t % total;
            c  = (t - 1) % total;
            nx = n % ht;
            ny = n / ht;
            cx = c % ht;
            cy = c / ht;
            e_hs  = (cx >= hs0 && cx < hs1) ? pol : ~pol;
            e_vs  = (cy >= vs0 && cy < vs1) ? pol : ~pol;
            e_vis = (cx < hvis) && (cy < vvis);
        end
        check_eq({tag, " x"},       32'(px),  32'(cx));
        check_eq({tag, " y"},       32'(py),  32'(cy % 512));
        check_eq({tag, " x_next"},  32'(pxn), 32'(nx));
        check_eq({tag, " y_next"},  32'(pyn), 32'(ny % 512));
        check_eq({tag, " hsync"},   32'(hs),  32'(e_hs));
        check_eq({tag, " vsync"},   32'(vs),  32'(e_vs));
        check_eq({tag, " visible"}, 32'(vis), 32'(e_vis));
        check_eq({tag, " frame"},   fr,       exp_fr);
    endtask

    task automatic check_a(input int t);
        check_pixel("A", t, 800, 525, 640, 480, 656, 752, 490, 492, 1'b0, 0,
                    a_px, a_pxn, a_py, a_pyn, a_fr, a_hs, a_vs, a_vis);
    endtask

    task automatic check_b(input int t, input int unsigned exp_fr);
        check_pixel("B", t, 16, 525, 8, 480, 10, 13, 490, 492, 1'b0, exp_fr,
                    b_px, b_pxn, b_py, b_pyn, b_fr, b_hs, b_vs, b_vis);
    endtask

    task automatic check_c(input int t);
        check_pixel("C", t, 16, 10, 8, 6, 10, 13, 7, 9, 1'b1, 32'(t / 160),
                    c_px, c_pxn, c_py, c_pyn, c_fr, c_hs, c_vs, c_vis);
    endtask

    task automatic check_all_reset();
        check_eq("A tick in reset", 32'(a_tick), 0);
        check_eq("B tick in reset", 32'(b_tick), 0);
        check_eq("C tick in reset", 32'(c_tick), 0);
        check_a(0);
        check_b(0, 0);
        check_c(0);
    endtask

    initial begin
        rst     = 1'b1;
        pause_a = 1'b0;
        pause_b = 1'b1;
        pause_c = 1'b0;
        repeat (3) @(negedge clk);
        check_all_reset();
        rst = 1'b0;

        fork
            begin : run_a
                for (int k = 1; k <= 802; k++) begin
                    @(negedge clk);
                    check_eq($sformatf("A tick k=%0d", k), 32'(a_tick), 1);
                    check_a(k - 1);
                end
            end
            begin : run_b
                int unsigned efr;
                for (int k = 1; k <= 16901; k++) begin
                    @(negedge clk);
`ifdef VGA_TIMING_PAUSE_EN
                    efr = (k - 1 >= 16800) ? 1 : 0;
`else
                    efr = 32'((k - 1) / 8400);
`endif
                    check_eq($sformatf("B tick k=%0d", k), 32'(b_tick), 1);
                    check_b(k - 1, efr);
                    if (k - 1 == 8405) pause_b = 1'b0;
                end
            end
            begin : run_c
                for (int j = 1; j <= 1300; j++) begin
                    @(negedge clk);
                    check_eq($sformatf("C tick j=%0d", j), 32'(c_tick), 32'((j % 4) == 3));
                    check_c(j / 4);
                end
            end
        join

        // One-cycle reset in the middle of B's frame; everything restarts from zero.
        rst = 1'b1;
        @(negedge clk);
        check_all_reset();
        rst = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            check_eq($sformatf("C tick after reset k=%0d", k), 32'(c_tick), 32'((k % 4) == 3));
            check_a(k - 1);
            check_b(k - 1, 0);
            check_c(k / 4);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
